multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUOP_WIDTH, default 3, SHALL set alu_op width; it must be 3 or more, and codes are zero-extended.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of the retired-instruction counter.
REQ-003 Parameter EN_JUMP, default 1; when 0, opcode J SHALL be treated as illegal.
REQ-004 Ports, with clock and reset first:
- clk  in  1  the single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- op  in  6  opcode from the instruction register.
- mem_ready  in  1  memory access complete this cycle.
- pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, lui  out  1 each  datapath controls.
- alu_src_b  out  2  ALU B-operand select: 0=reg, 1=const 4, 2=sign-extended immediate, 3=immediate shifted left by 2.
- pc_source  out  2  PC source: 0=ALU result, 1=ALUOut register, 2=jump target.
- alu_op  out  ALUOP_WIDTH  ALU operation code.
- illegal_op  out  1  pulse flagging an unsupported opcode.
- state  out  4  current state, for debug.
- instr_count  out  CNT_WIDTH  count of retired instructions.

Function
REQ-005 States and encodings SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JUMP=10, LUI_WB=11; encodings 12-15 SHALL go to FETCH on the next edge.
REQ-006 Supported opcodes SHALL be R=0x00, ADDI=0x08, ORI=0x0D, LUI=0x0F, LW=0x23, SW=0x2B, BEQ=0x04, BNE=0x05 and J=0x02.
REQ-007 All outputs SHALL decode combinationally from state, op_q and mem_ready; any control not listed for a state SHALL be 0.
REQ-008 FETCH outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD (3'b100), pc_source=0; ir_write and pc_write SHALL equal mem_ready.
REQ-009 FETCH transition: stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
REQ-010 DECODE outputs: alu_src_a=0, alu_src_b=3, alu_op=ADD, which precomputes the branch target.
REQ-011 DECODE SHALL latch op into op_q, and all later states SHALL use op_q only.
REQ-012 DECODE transitions: LW or SW goes to MEM_ADDR; R goes to EXEC_R; ADDI or ORI goes to EXEC_I; BEQ or BNE goes to BRANCH; J goes to JUMP; LUI goes to LUI_WB.
REQ-013 DECODE with any other opcode SHALL go to FETCH and drive illegal_op=1 for that DECODE cycle only.
REQ-014 MEM_ADDR outputs: alu_src_a=1, alu_src_b=2, alu_op=ADD. Transition: LW goes to MEM_RD; SW goes to MEM_WR.
REQ-015 MEM_RD outputs: mem_read=1, i_or_d=1. Hold while mem_ready=0; go to MEM_WB on mem_ready=1.
REQ-016 MEM_WB outputs: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
REQ-017 MEM_WR outputs: i_or_d=1, mem_write=1. Hold while mem_ready=0; go to FETCH on mem_ready=1.
REQ-018 EXEC_R outputs: alu_src_a=1, alu_src_b=0, alu_op=3'b111. EXEC_I outputs: alu_src_a=1, alu_src_b=2, alu_op=3'b100 for ADDI and 3'b101 for ORI. Both states go to ALU_WB.
REQ-019 ALU_WB outputs: reg_write=1, mem_to_reg=0, reg_dst=1 for R and 0 for ADDI/ORI. Go to FETCH.
REQ-020 BRANCH outputs: alu_src_a=1, alu_src_b=0, alu_op=SUB (3'b011), pc_source=1, pc_write_eq=1 for BEQ, pc_write_ne=1 for BNE. Go to FETCH.
REQ-021 JUMP outputs: pc_write=1, pc_source=2. Go to FETCH.
REQ-022 LUI_WB outputs: reg_write=1, lui=1, reg_dst=0, alu_op=3'b000. Go to FETCH.
REQ-023 instr_count SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP or LUI_WB.
REQ-024 instr_count SHALL NOT increment on the illegal-opcode return to FETCH.
REQ-025 instr_count SHALL wrap from all-ones to 0 with no flag.
REQ-026 Latency SHALL be: J=3 cycles, BEQ/BNE=3, R/ADDI/ORI=4, LUI=3, SW=4, LW=5, each counting one cycle per memory access with mem_ready=1; every mem_ready=0 cycle adds exactly one cycle.

Reset
REQ-027 While reset=0, the block SHALL hold state=FETCH, op_q=0 and instr_count=0.
REQ-028 While reset=0, pc_write, ir_write, reg_write, mem_write and illegal_op SHALL be 0 regardless of mem_ready.
REQ-029 Reset asserted mid-instruction, including during a mem_ready wait, SHALL abort immediately with no partial write and no count increment.
REQ-030 After reset is released, operation SHALL resume in FETCH on the first rising edge.

Verification
REQ-031 Reset with mem_ready=1, op=0x23 (LW) -> states 0,1,2,3,4,0; reg_write=1 only in state 4; instr_count=1.
REQ-032 FETCH with mem_ready=0 for 3 cycles, then 1, op=0x00 -> ir_write=0 for 3 cycles, then 1 for one cycle; total 7 cycles to the next FETCH.
REQ-033 op=0x05 (BNE) -> state 9 with pc_write_ne=1, pc_write_eq=0, alu_op=3'b011.
REQ-034 op=0x3F -> illegal_op=1 in DECODE for one cycle, next state 0, instr_count unchanged; with EN_JUMP=0, op=0x02 gives the same response.
REQ-035 Reset pulled low in MEM_WR while mem_ready=0 -> mem_write drops to 0 at once, state=0, instr_count=0.
REQ-036 CNT_WIDTH=4, 16 J instructions -> instr_count wraps from 15 to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: a state machine that sequences fetch, decode,
// memory, ALU, branch and jump steps, and counts the instructions it retires.
//   state    | meaning
//   FETCH    | read instruction, PC+4 when mem_ready
//   DECODE   | latch opcode, precompute branch target
//   MEM_ADDR | compute load/store address
//   MEM_RD   | data read, wait on mem_ready
//   MEM_WB   | write loaded data to register file
//   MEM_WR   | data write, wait on mem_ready
//   EXEC_R   | R-type ALU operation
//   EXEC_I   | immediate ALU operation
//   ALU_WB   | write ALU result to register file
//   BRANCH   | compare and conditionally update PC
//   JUMP     | load PC with jump target
//   LUI_WB   | write upper immediate to register file
module multicycle_control #(
  parameter int ALUOP_WIDTH = 3,
  parameter int CNT_WIDTH   = 16,
  parameter int EN_JUMP     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_eq,
  output logic                   pc_write_ne,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic                   lui,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             pc_source,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic                   illegal_op,
  output logic [3:0]             state,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_LUI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [ALUOP_WIDTH-1:0] ALU_LUI = ALUOP_WIDTH'(3'b000);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB = ALUOP_WIDTH'(3'b011);
  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD = ALUOP_WIDTH'(3'b100);
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR  = ALUOP_WIDTH'(3'b101);
  localparam logic [ALUOP_WIDTH-1:0] ALU_R   = ALUOP_WIDTH'(3'b111);

  state_e               state_q, state_d;
  logic [5:0]           op_q, op_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic pc_write_c, ir_write_c, reg_write_c, mem_write_c, illegal_c;
  logic retire;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pc_write_c  = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_write_c = 1'b0;
    alu_src_a   = 1'b0;
    lui         = 1'b0;
    alu_src_b   = 2'd0;
    pc_source   = 2'd0;
    alu_op      = '0;
    illegal_c   = 1'b0;
    retire      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'd1;
        alu_op     = ALU_ADD;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
        op_d      = op;
        // op_q is only being loaded now, so this state routes on the live opcode
        case (op)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_R:             state_d = S_EXEC_R;
          OP_ADDI, OP_ORI:  state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_LUI:           state_d = S_LUI_WB;
          OP_J: begin
            if (EN_JUMP != 0) begin
              state_d = S_JUMP;
            end else begin
              state_d   = S_FETCH;
              illegal_c = 1'b1;
            end
          end
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_ADD;
        if (op_q == OP_LW)      state_d = S_MEM_RD;
        else if (op_q == OP_SW) state_d = S_MEM_WR;
        else                    state_d = S_FETCH;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WR: begin
        i_or_d      = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_R;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        reg_dst     = (op_q == OP_R);
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_op      = ALU_SUB;
        pc_source   = 2'd1;
        pc_write_eq = (op_q == OP_BEQ);
        pc_write_ne = (op_q == OP_BNE);
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_source  = 2'd2;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI_WB: begin
        reg_write_c = 1'b1;
        lui         = 1'b1;
        alu_op      = ALU_LUI;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    cnt_d = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= 6'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write strobes are forced low the moment reset asserts, independent of mem_ready.
  assign pc_write    = pc_write_c  & reset;
  assign ir_write    = ir_write_c  & reset;
  assign reg_write   = reg_write_c & reset;
  assign mem_write   = mem_write_c & reset;
  assign illegal_op  = illegal_c   & reset;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state, controls and
// retired count are queued by the driver and compared on the falling edge.
module tb_multicycle_control;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MADDR = 2, ST_MRD = 3, ST_MWB = 4;
  localparam int ST_MWR = 5, ST_EXR = 6, ST_EXI = 7, ST_ALUWB = 8, ST_BR = 9;
  localparam int ST_JMP = 10, ST_LUIWB = 11;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, op_nj;
  logic       mem_ready;

  logic       pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, lui, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [3:0] instr_count;

  logic       pc_write_n, pc_write_eq_n, pc_write_ne_n, i_or_d_n, mem_read_n, mem_write_n;
  logic       ir_write_n, mem_to_reg_n, reg_dst_n, reg_write_n, alu_src_a_n, lui_n, illegal_op_n;
  logic [1:0] alu_src_b_n, pc_source_n;
  logic [2:0] alu_op_n;
  logic [3:0] state_n;
  logic [15:0] instr_count_n;

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_WIDTH(3), .CNT_WIDTH(4), .EN_JUMP(1)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .lui(lui), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  multicycle_control #(.ALUOP_WIDTH(3), .CNT_WIDTH(16), .EN_JUMP(0)) dut_nj (
    .clk(clk), .reset(reset), .op(op_nj), .mem_ready(mem_ready),
    .pc_write(pc_write_n), .pc_write_eq(pc_write_eq_n), .pc_write_ne(pc_write_ne_n),
    .i_or_d(i_or_d_n), .mem_read(mem_read_n), .mem_write(mem_write_n), .ir_write(ir_write_n),
    .mem_to_reg(mem_to_reg_n), .reg_dst(reg_dst_n), .reg_write(reg_write_n),
    .alu_src_a(alu_src_a_n), .lui(lui_n), .alu_src_b(alu_src_b_n), .pc_source(pc_source_n),
    .alu_op(alu_op_n), .illegal_op(illegal_op_n), .state(state_n), .instr_count(instr_count_n)
  );

  logic [19:0] ctrl_m;
  assign ctrl_m = {pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, lui, alu_src_b, pc_source,
                   alu_op, illegal_op};

  typedef struct {
    logic [3:0]  st;
    logic [19:0] ctrl;
    logic [3:0]  cnt;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [3:0] exp_cnt;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic legal(input logic [5:0] o);
    return o inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
  endfunction

  // Expected control word for a state, built field by field from the control table.
  function automatic logic [19:0] exp_ctrl(input int st, input logic [5:0] o, input logic mr);
    logic pw, peq, pne, iod, mrd, mwr, irw, m2r, rdst, rw, asa, lu, ill;
    logic [1:0] asb, psrc;
    logic [2:0] aop;
    {pw, peq, pne, iod, mrd, mwr, irw, m2r, rdst, rw, asa, lu, ill} = '0;
    asb = 2'd0; psrc = 2'd0; aop = 3'b000;
    case (st)
      ST_FETCH:  begin mrd = 1; asb = 2'd1; aop = 3'b100; irw = mr; pw = mr; end
      ST_DECODE: begin asb = 2'd3; aop = 3'b100; ill = !legal(o); end
      ST_MADDR:  begin asa = 1; asb = 2'd2; aop = 3'b100; end
      ST_MRD:    begin mrd = 1; iod = 1; end
      ST_MWB:    begin rw = 1; m2r = 1; end
      ST_MWR:    begin iod = 1; mwr = 1; end
      ST_EXR:    begin asa = 1; asb = 2'd0; aop = 3'b111; end
      ST_EXI:    begin asa = 1; asb = 2'd2; aop = (o == OP_ORI) ? 3'b101 : 3'b100; end
      ST_ALUWB:  begin rw = 1; rdst = (o == OP_R); end
      ST_BR:     begin asa = 1; aop = 3'b011; psrc = 2'd1; peq = (o == OP_BEQ); pne = (o == OP_BNE); end
      ST_JMP:    begin pw = 1; psrc = 2'd2; end
      ST_LUIWB:  begin rw = 1; lu = 1; aop = 3'b000; end
      default:   ;
    endcase
    return {pw, peq, pne, iod, mrd, mwr, irw, m2r, rdst, rw, asa, lu, asb, psrc, aop, ill};
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show during that cycle.
  task automatic step(input int st, input logic [5:0] drv_op, input logic mr, input logic [5:0] ref_op);
    exp_t e;
    op        = drv_op;
    mem_ready = mr;
    e.st   = 4'(st);
    e.ctrl = exp_ctrl(st, ref_op, mr);
    e.cnt  = exp_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [5:0] o, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(ST_FETCH, o, 1'b0, o);
    step(ST_FETCH, o, 1'b1, o);
    step(ST_DECODE, o, rbit(), o);
    case (o)
      OP_LW: begin
        step(ST_MADDR, rop(), rbit(), o);
        for (int i = 0; i < mw; i++) step(ST_MRD, rop(), 1'b0, o);
        step(ST_MRD, rop(), 1'b1, o);
        step(ST_MWB, rop(), rbit(), o);
      end
      OP_SW: begin
        step(ST_MADDR, rop(), rbit(), o);
        for (int i = 0; i < mw; i++) step(ST_MWR, rop(), 1'b0, o);
        step(ST_MWR, rop(), 1'b1, o);
      end
      OP_R: begin
        step(ST_EXR, rop(), rbit(), o);
        step(ST_ALUWB, rop(), rbit(), o);
      end
      OP_ADDI, OP_ORI: begin
        step(ST_EXI, rop(), rbit(), o);
        step(ST_ALUWB, rop(), rbit(), o);
      end
      OP_BEQ, OP_BNE: step(ST_BR, rop(), rbit(), o);
      OP_J:           step(ST_JMP, rop(), rbit(), o);
      OP_LUI:         step(ST_LUIWB, rop(), rbit(), o);
      default: ;
    endcase
    if (legal(o)) exp_cnt = exp_cnt + 4'd1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_eq("state", 32'(state), 32'(mon_e.st));
      check_eq("ctrl", 32'(ctrl_m), 32'(mon_e.ctrl));
      check_eq("count", 32'(instr_count), 32'(mon_e.cnt));
    end
    if (reset) begin
      check_eq("nj_illegal", 32'(illegal_op_n), 32'(state_n == 4'd1));
      check_eq("nj_count", 32'(instr_count_n), 32'd0);
      check_eq("nj_no_jump", 32'(state_n <= 4'd1), 32'd1);
    end
  end

  logic [5:0] op_tbl [11];

  initial begin
    op_tbl = '{OP_R, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, 6'h3F, 6'h10};
    reset = 1'b0; mem_ready = 1'b1; op = OP_LW; op_nj = OP_J; exp_cnt = 4'd0;

    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_count", 32'(instr_count), 32'd0);
    check_eq("rst_strobes", 32'({pc_write, ir_write, reg_write, mem_write, illegal_op}), 32'd0);

    @(posedge clk); #1;
    reset = 1'b1;

    do_instr(OP_LW, 0, 0);
    do_instr(OP_R, 3, 0);
    do_instr(OP_BNE, 0, 0);
    do_instr(OP_BEQ, 1, 0);
    do_instr(OP_ADDI, 0, 0);
    do_instr(OP_ORI, 0, 0);
    do_instr(OP_LUI, 0, 0);
    do_instr(OP_SW, 0, 2);
    do_instr(OP_LW, 1, 1);
    do_instr(OP_J, 0, 0);
    do_instr(6'h3F, 0, 0);
    do_instr(6'h10, 2, 0);

    // Abort a store that is stalled on mem_ready.
    step(ST_FETCH, OP_SW, 1'b1, OP_SW);
    step(ST_DECODE, OP_SW, 1'b1, OP_SW);
    step(ST_MADDR, rop(), 1'b1, OP_SW);
    step(ST_MWR, rop(), 1'b0, OP_SW);
    #1;
    check_eq("mwr_hold_state", 32'(state), 32'd5);
    check_eq("mwr_hold_write", 32'(mem_write), 32'd1);
    check_eq("mwr_hold_count", 32'(instr_count), 32'(exp_cnt));
    reset = 1'b0;
    #1;
    check_eq("abort_write", 32'(mem_write), 32'd0);
    check_eq("abort_state", 32'(state), 32'd0);
    check_eq("abort_count", 32'(instr_count), 32'd0);
    mem_ready = 1'b1;
    #1;
    check_eq("abort_strobes", 32'({pc_write, ir_write, reg_write, mem_write, illegal_op}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    exp_cnt = 4'd0;
    reset = 1'b1;

    for (int i = 0; i < 16; i++) do_instr(OP_J, 0, 0);
    check_eq("wrap_count", 32'(instr_count), 32'd0);

    for (int i = 0; i < 30; i++)
      do_instr(op_tbl[$urandom_range(0, 10)], $urandom_range(0, 2), $urandom_range(0, 2));

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
